// File: rtl/idecode_pkg.sv
// Shared definitions for the bexkat1 decode stage: instruction field positions,
// the instruction type enum and the decoded-instruction record.
package bexkat1Def;

    localparam int NREGS_DEF  = 16;
    localparam int REG_IDX_W  = 4;

    localparam int TYPE_LSB   = 28;
    localparam int OPCODE_LSB = 24;
    localparam int RA_LSB     = 20;
    localparam int RB_LSB     = 16;
    localparam int RC_LSB     = 12;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [3:0] {
        T_INH    = 4'd0,
        T_IMM    = 4'd1,
        T_REG    = 4'd2,
        T_LDI    = 4'd3,
        T_LOAD   = 4'd4,
        T_STORE  = 4'd5,
        T_BRANCH = 4'd6,
        T_JUMP   = 4'd7
    } type_t;

    typedef struct packed {
        logic [63:0] ir;
        logic [31:0] pc;
        reg_idx_t    ra;
        reg_idx_t    rb;
        reg_idx_t    rc;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] imm;
    } dec_t;

    function automatic type_t ir_type(input logic [63:0] ir);
        return type_t'(ir[TYPE_LSB +: 4]);
    endfunction

    function automatic logic [3:0] ir_opcode(input logic [63:0] ir);
        return ir[OPCODE_LSB +: 4];
    endfunction

    function automatic reg_idx_t ir_ra(input logic [63:0] ir);
        return ir[RA_LSB +: REG_IDX_W];
    endfunction

    function automatic reg_idx_t ir_rb(input logic [63:0] ir);
        return ir[RB_LSB +: REG_IDX_W];
    endfunction

    function automatic reg_idx_t ir_rc(input logic [63:0] ir);
        return ir[RC_LSB +: REG_IDX_W];
    endfunction

    // Long instructions carry a full 32-bit immediate in the second word.
    function automatic logic [31:0] ir_imm(input logic [63:0] ir);
        return ir[0] ? ir[63:32] : {{16{ir[15]}}, ir[15:0]};
    endfunction

    function automatic logic writes_reg(input type_t t);
        return (t == T_INH) || (t == T_IMM) || (t == T_REG) || (t == T_LDI);
    endfunction

endpackage

// File: rtl/idecode_if.sv
// Fetch-side, execute-side and writeback signals of the decode stage.
interface idecode_if;
    import bexkat1Def::*;

    logic [63:0] ir_i;
    logic [31:0] pc_i;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;

    logic        valid_o;
    logic        ready_i;
    logic [63:0] ir_o;
    logic [31:0] pc_o;
    reg_idx_t    ra_o;
    reg_idx_t    rb_o;
    reg_idx_t    rc_o;
    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic [31:0] imm_o;

    logic        wb_we_i;
    reg_idx_t    wb_addr_i;
    logic [31:0] wb_data_i;

    modport slave (
        input  ir_i, pc_i, valid_i, flush_i, ready_i,
        input  wb_we_i, wb_addr_i, wb_data_i,
        output ready_o, valid_o, ir_o, pc_o, ra_o, rb_o, rc_o,
        output data1_o, data2_o, imm_o
    );

    modport master (
        output ir_i, pc_i, valid_i, flush_i, ready_i,
        output wb_we_i, wb_addr_i, wb_data_i,
        input  ready_o, valid_o, ir_o, pc_o, ra_o, rb_o, rc_o,
        input  data1_o, data2_o, imm_o
    );

endinterface

// File: rtl/idecode_registerfile.sv
// General register file: two combinational read ports with writeback bypass,
// one synchronous write port.
module registerfile
    import bexkat1Def::*;
#(
    parameter int NREGS = NREGS_DEF
) (
    input  logic        clk_i,
    input  reg_idx_t    raddr1_i,
    input  reg_idx_t    raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  reg_idx_t    waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] mem_q [NREGS];

    // NOTE: the array has no reset on purpose; the scoreboard, not the data,
    // says what is valid, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A write landing this cycle is forwarded so the reader sees the new value.
    always_comb begin
        rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
        rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];
    end

endmodule

// File: rtl/idecode.sv
// bexkat1 decode stage: register read, busy-register scoreboard and a one-deep
// valid/ready output register towards execute.
module idecode
    import bexkat1Def::*;
#(
    parameter int          NREGS    = NREGS_DEF,
    parameter logic [63:0] RESET_IR = 64'h0
) (
    input logic      clk_i,
    input logic      rst_i,
    idecode_if.slave bus
);

    localparam dec_t OUT_RESET = '{
        ir: RESET_IR, pc: '0, ra: '0, rb: '0, rc: '0,
        data1: '0, data2: '0, imm: '0
    };

    reg_idx_t         ra_in;
    reg_idx_t         rb_in;
    reg_idx_t         rc_in;
    logic [31:0]      rdata1;
    logic [31:0]      rdata2;
    logic             hazard;
    logic             ready;
    logic             accept;
    logic             held_writes;

    logic             valid_q, valid_d;
    logic [NREGS-1:0] busy_q, busy_d;
    dec_t             out_q, out_d;

    registerfile #(.NREGS(NREGS)) u_regfile (
        .clk_i    (clk_i),
        .raddr1_i (rb_in),
        .raddr2_i (rc_in),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2),
        .we_i     (bus.wb_we_i),
        .waddr_i  (bus.wb_addr_i),
        .wdata_i  (bus.wb_data_i)
    );

    always_comb begin
        ra_in       = ir_ra(bus.ir_i);
        rb_in       = ir_rb(bus.ir_i);
        rc_in       = ir_rc(bus.ir_i);
        hazard      = bus.valid_i && (busy_q[rb_in] || busy_q[rc_in]);
        ready       = (!valid_q || bus.ready_i) && !hazard && !bus.flush_i;
        accept      = bus.valid_i && ready;
        held_writes = valid_q && writes_reg(ir_type(out_q.ir));
    end

    // Later assignments win: a new writer's set overrides a same-index writeback clear.
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        busy_d = busy_q;
        if (bus.wb_we_i) begin
            busy_d[bus.wb_addr_i] = 1'b0;
        end
        if (bus.flush_i && held_writes) begin
            busy_d[out_q.ra] = 1'b0;
        end
        if (accept && writes_reg(ir_type(bus.ir_i))) begin
            busy_d[ra_in] = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        if (bus.flush_i) begin
            valid_d  = 1'b0;
            out_d.ir = RESET_IR;
        end else if (accept) begin
            valid_d     = 1'b1;
            out_d.ir    = bus.ir_i;
            out_d.pc    = bus.pc_i;
            out_d.ra    = ra_in;
            out_d.rb    = rb_in;
            out_d.rc    = rc_in;
            out_d.data1 = rdata1;
            out_d.data2 = rdata2;
            out_d.imm   = ir_imm(bus.ir_i);
        end else if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            busy_q  <= '0;
            out_q   <= OUT_RESET;
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            out_q   <= out_d;
        end
    end

    assign bus.ready_o = ready;
    assign bus.valid_o = valid_q;
    assign bus.ir_o    = out_q.ir;
    assign bus.pc_o    = out_q.pc;
    assign bus.ra_o    = out_q.ra;
    assign bus.rb_o    = out_q.rb;
    assign bus.rc_o    = out_q.rc;
    assign bus.data1_o = out_q.data1;
    assign bus.data2_o = out_q.data2;
    assign bus.imm_o   = out_q.imm;

endmodule

// File: tb/tb_idecode.sv
// Self-checking bench for idecode: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the decode stage.
module tb_idecode;

    localparam logic [63:0] RST_IR = 64'h0000_0000_F00D_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    idecode_if bus ();

    idecode #(.NREGS(16), .RESET_IR(RST_IR)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    logic last_ready;

    // Behavioural model state
    logic [31:0] m_regs [16];
    bit          m_busy [16];
    bit          m_valid;
    logic [63:0] m_ir;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [3:0]  m_ra, m_rb, m_rc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_writer(input logic [63:0] ir);
        return ir[31:28] <= 4'd3;
    endfunction

    function automatic logic [63:0] mk_ir(input logic [3:0] t, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [15:0] lo,
                                          input logic [31:0] hi);
        return {hi, t, 4'h0, ra, rb, lo};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_ir = RST_IR;
        m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
        m_ra = '0; m_rb = '0; m_rc = '0;
    endtask

    task automatic compare_outputs();
        check("valid_o", bus.valid_o, m_valid);
        check("ir_o",    bus.ir_o,    m_ir);
        check("pc_o",    bus.pc_o,    m_pc);
        check("ra_o",    bus.ra_o,    m_ra);
        check("rb_o",    bus.rb_o,    m_rb);
        check("rc_o",    bus.rc_o,    m_rc);
        check("data1_o", bus.data1_o, m_d1);
        check("data2_o", bus.data2_o, m_d2);
        check("imm_o",   bus.imm_o,   m_imm);
    endtask

    // One clock: drive at negedge, check ready_o, advance model at posedge, check outputs.
    task automatic cycle(input bit valid, input logic [63:0] ir, input logic [31:0] pc,
                         input bit rdy, input bit flush,
                         input bit we, input logic [3:0] waddr, input logic [31:0] wdata);
        bit         exp_ready, acc, old_wr;
        logic [3:0] old_ra, ra, rb, rc;
        @(negedge clk);
        bus.valid_i   = valid;
        bus.ir_i      = ir;
        bus.pc_i      = pc;
        bus.ready_i   = rdy;
        bus.flush_i   = flush;
        bus.wb_we_i   = we;
        bus.wb_addr_i = waddr;
        bus.wb_data_i = wdata;
        #1;
        ra = ir[23:20];
        rb = ir[19:16];
        rc = ir[15:12];
        exp_ready  = (!m_valid || rdy) && !(valid && (m_busy[rb] || m_busy[rc])) && !flush;
        last_ready = bus.ready_o;
        check("ready_o", bus.ready_o, exp_ready);
        acc = valid && exp_ready;
        @(posedge clk);
        old_wr = m_valid && is_writer(m_ir);
        old_ra = m_ra;
        if (we) m_busy[waddr] = 1'b0;
        if (flush && old_wr) m_busy[old_ra] = 1'b0;
        if (acc && is_writer(ir)) m_busy[ra] = 1'b1;
        if (flush) begin
            m_valid = 1'b0;
            m_ir    = RST_IR;
        end else if (acc) begin
            m_valid = 1'b1;
            m_ir    = ir;
            m_pc    = pc;
            m_ra    = ra;
            m_rb    = rb;
            m_rc    = rc;
            m_d1    = (we && waddr == rb) ? wdata : m_regs[rb];
            m_d2    = (we && waddr == rc) ? wdata : m_regs[rc];
            m_imm   = ir[0] ? ir[63:32] : 32'($signed(ir[15:0]));
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (we) m_regs[waddr] = wdata;
        #1;
        compare_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a_ir, b_ir, w_ir, r_ir;
        bus.valid_i = 1'b0; bus.ir_i = '0; bus.pc_i = '0; bus.ready_i = 1'b1;
        bus.flush_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_addr_i = '0; bus.wb_data_i = '0;
        model_reset();

        // Reset state
        #12;
        check("rst_valid_o", bus.valid_o, 1'b0);
        check("rst_ir_o",    bus.ir_o,    RST_IR);
        check("rst_pc_o",    bus.pc_o,    32'h0);
        check("rst_data1_o", bus.data1_o, 32'h0);
        check("rst_imm_o",   bus.imm_o,   32'h0);
        check("rst_ready_o", bus.ready_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Give every register a known value before anything reads it
        for (int i = 0; i < 16; i++) cycle(0, '0, '0, 1, 0, 1, 4'(i), $urandom);

        // Written register read through decode
        cycle(0, '0, '0, 1, 0, 1, 4'd3, 32'h1234);
        cycle(1, mk_ir(4'h8, 4'd0, 4'd3, 16'h0000, 32'h0), 32'h100, 1, 0, 0, '0, '0);
        check("wr_rd_valid", bus.valid_o, 1'b1);
        check("wr_rd_data1", bus.data1_o, 32'h1234);

        // RAW hazard on r5 stalls until its writeback
        cycle(1, mk_ir(4'h0, 4'd5, 4'd1, 16'h2000, 32'h0), 32'h104, 1, 0, 0, '0, '0);
        check("raw_issue", last_ready, 1'b1);
        r_ir = mk_ir(4'h8, 4'd0, 4'd5, 16'h3000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, r_ir, 32'h108, 1, 0, 0, '0, '0);
            check("raw_stall", last_ready, 1'b0);
        end
        cycle(1, r_ir, 32'h108, 1, 0, 1, 4'd5, 32'hCAFE);
        check("raw_stall_wb", last_ready, 1'b0);
        cycle(1, r_ir, 32'h108, 1, 0, 0, '0, '0);
        check("raw_release", last_ready, 1'b1);
        check("raw_data1", bus.data1_o, 32'hCAFE);

        // Long and short immediates
        cycle(1, 64'hDEADBEEF_00000001, 32'h10C, 1, 0, 0, '0, '0);
        check("imm_long", bus.imm_o, 32'hDEADBEEF);
        cycle(1, mk_ir(4'h8, 4'd0, 4'd1, 16'h8000, 32'h0), 32'h110, 1, 0, 0, '0, '0);
        check("imm_short_acc", last_ready, 1'b1);
        check("imm_short", bus.imm_o, 32'hFFFF8000);
        cycle(0, '0, '0, 1, 0, 1, 4'd0, 32'h0BAD);

        // Backpressure: held outputs stay put
        a_ir = mk_ir(4'h9, 4'd0, 4'd2, 16'h4000, 32'h1111);
        b_ir = mk_ir(4'hA, 4'd0, 4'd4, 16'h2000, 32'h2222);
        cycle(1, a_ir, 32'h200, 1, 0, 0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, b_ir, 32'h204, 0, 0, 0, '0, '0);
            check("bp_ready", last_ready, 1'b0);
            check("bp_ir_hold", bus.ir_o, a_ir);
            check("bp_pc_hold", bus.pc_o, 32'h200);
        end
        cycle(1, b_ir, 32'h204, 1, 0, 0, '0, '0);
        check("bp_release", last_ready, 1'b1);
        check("bp_next_ir", bus.ir_o, b_ir);

        // Flush a held writer of r7 together with an incoming writer of r8
        w_ir = mk_ir(4'h1, 4'd7, 4'd3, 16'h3000, 32'h0);
        cycle(1, w_ir, 32'h300, 1, 0, 0, '0, '0);
        cycle(1, mk_ir(4'h2, 4'd8, 4'd3, 16'h3000, 32'h0), 32'h304, 0, 1, 0, '0, '0);
        check("flush_ready", last_ready, 1'b0);
        check("flush_valid", bus.valid_o, 1'b0);
        check("flush_ir", bus.ir_o, RST_IR);
        r_ir = mk_ir(4'h8, 4'd0, 4'd7, 16'h8000, 32'h0);
        cycle(1, r_ir, 32'h308, 1, 0, 0, '0, '0);
        check("flush_busy_clear", last_ready, 1'b1);
        check("flush_next_ir", bus.ir_o, r_ir);

        // Asynchronous reset in the middle of a stall
        cycle(1, mk_ir(4'h3, 4'd9, 4'd3, 16'h3000, 32'h0), 32'h400, 1, 0, 0, '0, '0);
        r_ir = mk_ir(4'h8, 4'd0, 4'd9, 16'h9000, 32'h0);
        cycle(1, r_ir, 32'h404, 0, 0, 0, '0, '0);
        check("arst_stall", last_ready, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", bus.valid_o, 1'b0);
        check("arst_ready", bus.ready_o, 1'b1);
        check("arst_ir",    bus.ir_o,    RST_IR);
        check("arst_pc",    bus.pc_o,    32'h0);
        check("arst_data1", bus.data1_o, 32'h0);
        model_reset();
        @(negedge clk);
        bus.valid_i = 1'b0;
        rst_n = 1'b1;
        cycle(1, r_ir, 32'h404, 0, 0, 0, '0, '0);
        check("arst_busy_clear", last_ready, 1'b1);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            bit          v, rdy, fl, we;
            logic [3:0]  wa;
            logic [63:0] ir;
            int          busy_list[$];
            v   = ($urandom % 10) < 7;
            rdy = ($urandom % 10) < 7;
            fl  = ($urandom % 20) == 0;
            we  = ($urandom % 10) < 3;
            ir  = {$urandom, $urandom};
            wa  = 4'($urandom);
            busy_list.delete();
            foreach (m_busy[i]) if (m_busy[i]) busy_list.push_back(i);
            if (we && busy_list.size() > 0 && ($urandom % 2) == 1)
                wa = 4'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
            cycle(v, ir, $urandom, rdy, fl, we, wa, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/idecode.md
IDECODE -- requirements
Module: idecode

Interface
REQ-001 The block SHALL have parameter NREGS, default 16, number of general registers (index width 4).
REQ-002 The block SHALL have parameter RESET_IR, default 64'h0, ir_o value after reset/flush.
REQ-003 clk_i  in  1  single clock, all state on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 ir_i  in  64  instruction from fetch stage; [63:32] valid only when ir_i[0]=1.
REQ-006 pc_i  in  32  address of ir_i.
REQ-007 valid_i  in  1  ir_i/pc_i hold a complete instruction.
REQ-008 ready_o  out  1  decode accepts ir_i this cycle.
REQ-009 valid_o  out  1  output register holds a decoded instruction.
REQ-010 ready_i  in  1  execute stage accepts the output register.
REQ-011 flush_i  in  1  branch taken; kill held and incoming instruction (pairs with fetch pc_set).
REQ-012 ir_o, pc_o  out  64/32  latched instruction and address.
REQ-013 ra_o, rb_o, rc_o  out  4 each  latched fields ir[23:20], ir[19:16], ir[15:12].
REQ-014 data1_o, data2_o  out  32 each  register values of fields rb and rc at acceptance.
REQ-015 imm_o  out  32  ir[63:32] if ir[0]=1, else sign-extended ir[15:0].
REQ-016 wb_we_i, wb_addr_i, wb_data_i  in  1/4/32  writeback port to the register file.

Function
REQ-017 Fields SHALL be type=ir[31:28], opcode=ir[27:24]; an instruction writes ra when type is 0..3 (package function).
REQ-018 Acceptance SHALL occur when valid_i && ready_o; ready_o = (!valid_o || ready_i) && !hazard && !flush_i.
REQ-019 hazard SHALL be valid_i && (busy[rb] || busy[rc]), busy being a NREGS-bit scoreboard register.
REQ-020 On acceptance the output register SHALL load next edge: latency exactly one cycle, valid_o=1.
REQ-021 When valid_o && ready_i and no acceptance, valid_o SHALL clear next edge.
REQ-022 While valid_o && !ready_i, all outputs SHALL hold stable.
REQ-023 Register reads SHALL bypass: if wb_we_i and wb_addr_i equals a read index in the accept cycle, wb_data_i is latched.
REQ-024 Register file write SHALL occur at edge when wb_we_i=1; write and read same cycle follow REQ-023.
REQ-025 Accepting a writing instruction SHALL set busy[ra]; wb_we_i SHALL clear busy[wb_addr_i]; same index same cycle: set wins.
REQ-026 flush_i SHALL, next edge, clear valid_o, load ir_o=RESET_IR, and clear busy bit of the held instruction's ra if it writes; busy bits of older instructions untouched.
REQ-027 flush_i together with valid_i SHALL discard ir_i (no acceptance, no busy set).
REQ-028 Hazard on rb/rc equal to the held instruction's ra SHALL stall until its writeback.

Reset
REQ-029 rst_i low SHALL asynchronously force valid_o=0, busy=0, ir_o=RESET_IR, pc_o=0, fields/data/imm=0.
REQ-030 Register file contents SHALL NOT be reset; reset mid-stall drops the held instruction.

Structure
REQ-031 Field positions, type_t enum, writes_reg() function and NREGS default SHALL live in package bexkat1Def.
REQ-032 The register file (2 read, 1 write, no reset) SHALL be sub-module registerfile.
REQ-033 Scoreboard and handshake logic SHALL stay in idecode.

Verification
REQ-034 Write r3=32'h1234 via wb, then issue rb=3 -> one cycle later valid_o=1, data1_o=32'h1234.
REQ-035 Issue writer ra=5, next issue rb=5 -> ready_o=0 until wb_we_i addr 5 data 32'hCAFE; data1_o=32'hCAFE.
REQ-036 Long ir_i=64'hDEADBEEF_00000001 -> imm_o=32'hDEADBEEF; short ir[15:0]=16'h8000 -> imm_o=32'hFFFF8000.
REQ-037 Hold ready_i=0 for 3 cycles with valid_i=1 -> ready_o=0, outputs constant; release -> next instruction loads.
REQ-038 flush_i with writer ra=7 held -> valid_o=0, busy[7]=0, incoming instruction dropped.
REQ-039 Assert rst_i low mid-stall -> valid_o=0, busy=0 immediately, without a clock edge.
